spdif_timebase: RTL and testbench
=================================

SPDIF_TIMEBASE -- requirements
Module: spdif_timebase

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of the divide-ratio path.
REQ-002 SHALL have parameter DIV_RESET, default 4, divide ratio in force after reset.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port nrst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  count enable; low freezes all state.
REQ-006 SHALL have port sync_clr  input  1  synchronous clear of counters and indices.
REQ-007 SHALL have port div_i  input  WIDTH  requested divide ratio (clk cycles per biphase cell).
REQ-008 SHALL have port div_load  input  1  one-cycle strobe capturing div_i.
REQ-009 SHALL have port div_busy  output  1  high while a captured ratio awaits application.
REQ-010 SHALL have port out  output  1  divided clock, toggles once per cell, period 2*ratio.
REQ-011 SHALL have port cell_stb  output  1  one-cycle pulse per biphase cell.
REQ-012 SHALL have port bit_stb  output  1  one-cycle pulse per S/PDIF bit (every second cell).
REQ-013 SHALL have port bit_idx  output  5  bit slot within subframe, 0..31.
REQ-014 SHALL have port sub_idx  output  1  subframe, 0 = A, 1 = B.
REQ-015 SHALL have port frame_idx  output  8  frame within block, 0..191.
REQ-016 SHALL have port block_stb  output  1  one-cycle pulse when a new block starts.

Function
REQ-017 SHALL count enabled cycles 0..ratio-1 in a WIDTH-bit counter, wrapping to 0.
REQ-018 SHALL raise cell_stb (registered) for exactly one cycle in the cycle after the counter wraps; with en held high, cell_stb pulses every ratio cycles, first pulse ratio cycles after first enabled edge.
REQ-019 SHALL toggle out and a cell-phase bit on each cell_stb; bit_stb = cell_stb coincident with phase transitioning 1->0 (second cell of a bit).
REQ-020 SHALL increment bit_idx on bit_stb, wrapping 31->0; on that wrap toggle sub_idx.
REQ-021 SHALL increment frame_idx when sub_idx wraps B->A, wrapping 191->0, and pulse block_stb for one cycle coincident with that 191->0 wrap.
REQ-022 SHALL capture div_i on div_load into a pending register and set div_busy next cycle.
REQ-023 SHALL apply pending ratio only at a cell boundary (counter wrap), clear div_busy the same cycle; out duty never glitches.
REQ-024 SHALL let a div_load while div_busy overwrite the pending value, application still at next boundary.
REQ-025 SHALL clamp captured ratios below 2 to 2.
REQ-026 SHALL hold counter, out, phase, indices and div_busy while en low; strobes forced 0; div_load still captured.
REQ-027 SHALL on sync_clr (priority over en) zero counter, phase, out, bit_idx, sub_idx, frame_idx, strobes; pending ratio and div_busy unaffected.
REQ-028 SHALL give div_load and sync_clr in the same cycle both effects.

Reset
REQ-029 SHALL on nrst low asynchronously set counter 0, ratio DIV_RESET, pending 0, div_busy 0, out 0, phase 0, cell_stb 0, bit_stb 0, block_stb 0, bit_idx 0, sub_idx 0, frame_idx 0.
REQ-030 SHALL resume counting on the first rising edge after nrst release with en high; reset mid-ratio-change discards pending value.

Structure
REQ-031 SHALL take BITS_PER_SUB=32, FRAMES_PER_BLOCK=192, MIN_DIV=2 from shared package spdif_pkg.
REQ-032 SHALL place counter, ratio/pending registers and cell_stb in sub-module clk_div_core; index counters in top level.

Verification
REQ-033 Reset, en=1, default ratio 4 -> cell_stb every 4 cycles, out period 8 cycles, bit_stb every 8 cycles.
REQ-034 div_i=6 loaded mid-cell -> div_busy high until next wrap, then cell spacing 6, out has no short pulse.
REQ-035 div_i=1 loaded -> ratio 2 applied, cell_stb every 2 cycles.
REQ-036 Run 64*192 bit_stb at ratio 2 -> bit_idx/sub_idx/frame_idx wrap to 0, exactly one block_stb.
REQ-037 en low 10 cycles mid-cell -> indices and out frozen, no strobes, resume with remaining count.
REQ-038 nrst pulse while div_busy with frame_idx=100 -> all outputs to reset values, ratio back to 4.

Source files
------------

// File: rtl/spdif_pkg.sv
// Shared S/PDIF framing constants used by the timebase and its divider core.
package spdif_pkg;
  localparam int unsigned BITS_PER_SUB     = 32;
  localparam int unsigned FRAMES_PER_BLOCK = 192;
  localparam int unsigned MIN_DIV          = 2;
  localparam int unsigned BIT_IDX_W        = 5;
  localparam int unsigned FRAME_IDX_W      = 8;
endpackage

// File: rtl/clk_div_core.sv
// Biphase-cell divider: programmable ratio counter with boundary-safe ratio
// updates, the divided clock and the cell-phase bit.
module clk_div_core
  import spdif_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_RESET = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [WIDTH-1:0] div_i,
  input  logic             div_load,
  output logic             div_busy,
  output logic             out,
  output logic             phase,
  output logic             cell_stb,
  output logic             wrap_c
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] ratio;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] div_clamped_c;

  assign div_clamped_c = (div_i < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : div_i;
  assign wrap_c        = en && !sync_clr && (cnt == ratio - WIDTH'(1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      ratio    <= WIDTH'(DIV_RESET);
      pending  <= '0;
      div_busy <= 1'b0;
      out      <= 1'b0;
      phase    <= 1'b0;
      cell_stb <= 1'b0;
    end else begin
      // A new ratio only takes effect as the counter wraps, so no cell is cut short
      if (div_load) begin
        pending  <= div_clamped_c;
        div_busy <= 1'b1;
      end else if (wrap_c && div_busy) begin
        div_busy <= 1'b0;
      end
      if (wrap_c && div_busy) begin
        ratio <= pending;
      end

      if (sync_clr) begin
        cnt      <= '0;
        out      <= 1'b0;
        phase    <= 1'b0;
        cell_stb <= 1'b0;
      end else if (en) begin
        cell_stb <= wrap_c;
        if (wrap_c) begin
          cnt   <= '0;
          out   <= ~out;
          phase <= ~phase;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end else begin
        cell_stb <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spdif_timebase.sv
// S/PDIF timebase: divided cell clock plus bit / subframe / frame position
// counters and their strobes.
module spdif_timebase
  import spdif_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DIV_RESET = 4
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   en,
  input  logic                   sync_clr,
  input  logic [WIDTH-1:0]       div_i,
  input  logic                   div_load,
  output logic                   div_busy,
  output logic                   out,
  output logic                   cell_stb,
  output logic                   bit_stb,
  output logic [BIT_IDX_W-1:0]   bit_idx,
  output logic                   sub_idx,
  output logic [FRAME_IDX_W-1:0] frame_idx,
  output logic                   block_stb
);

  logic phase;
  logic wrap_c;
  logic bit_end_c;
  logic sub_end_c;
  logic frame_end_c;
  logic block_end_c;

  clk_div_core #(
    .WIDTH     (WIDTH),
    .DIV_RESET (DIV_RESET)
  ) u_core (
    .clk      (clk),
    .nrst     (nrst),
    .en       (en),
    .sync_clr (sync_clr),
    .div_i    (div_i),
    .div_load (div_load),
    .div_busy (div_busy),
    .out      (out),
    .phase    (phase),
    .cell_stb (cell_stb),
    .wrap_c   (wrap_c)
  );

  // A bit ends on the wrap that closes its second cell (phase going 1 -> 0)
  assign bit_end_c   = wrap_c && phase;
  assign sub_end_c   = bit_end_c && (bit_idx == BIT_IDX_W'(BITS_PER_SUB - 1));
  assign frame_end_c = sub_end_c && sub_idx;
  assign block_end_c = frame_end_c && (frame_idx == FRAME_IDX_W'(FRAMES_PER_BLOCK - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bit_stb   <= 1'b0;
      block_stb <= 1'b0;
      bit_idx   <= '0;
      sub_idx   <= 1'b0;
      frame_idx <= '0;
    end else if (sync_clr) begin
      bit_stb   <= 1'b0;
      block_stb <= 1'b0;
      bit_idx   <= '0;
      sub_idx   <= 1'b0;
      frame_idx <= '0;
    end else if (en) begin
      bit_stb   <= bit_end_c;
      block_stb <= block_end_c;
      if (bit_end_c) begin
        bit_idx <= sub_end_c ? '0 : bit_idx + BIT_IDX_W'(1);
      end
      if (sub_end_c) begin
        sub_idx <= ~sub_idx;
      end
      if (frame_end_c) begin
        frame_idx <= block_end_c ? '0 : frame_idx + FRAME_IDX_W'(1);
      end
    end else begin
      bit_stb   <= 1'b0;
      block_stb <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spdif_timebase.sv
// Directed bench for spdif_timebase: default ratio, ratio changes, clamping,
// enable freeze, full block wrap and reset during a pending ratio change.
module tb_spdif_timebase;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             nrst;
  logic             en;
  logic             sync_clr;
  logic [WIDTH-1:0] div_i;
  logic             div_load;
  logic             div_busy;
  logic             out;
  logic             cell_stb;
  logic             bit_stb;
  logic [4:0]       bit_idx;
  logic             sub_idx;
  logic [7:0]       frame_idx;
  logic             block_stb;

  int checks = 0;
  int errors = 0;

  spdif_timebase #(.WIDTH(WIDTH), .DIV_RESET(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .sync_clr  (sync_clr),
    .div_i     (div_i),
    .div_load  (div_load),
    .div_busy  (div_busy),
    .out       (out),
    .cell_stb  (cell_stb),
    .bit_stb   (bit_stb),
    .bit_idx   (bit_idx),
    .sub_idx   (sub_idx),
    .frame_idx (frame_idx),
    .block_stb (block_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; en = 1'b0; sync_clr = 1'b0; div_load = 1'b0; div_i = '0;
    repeat (3) tick();
    checks++;
    if ({div_busy, out, cell_stb, bit_stb, block_stb} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000", {div_busy, out, cell_stb, bit_stb, block_stb});
    end
    checks++;
    if ({bit_idx, sub_idx, frame_idx} !== 14'd0) begin
      errors++;
      $display("FAIL reset_idx got bit=%0d sub=%0d frame=%0d exp 0", bit_idx, sub_idx, frame_idx);
    end
    nrst = 1'b1;
    en   = 1'b1;
  endtask

  task automatic test_default_ratio();
    logic exp_cell, exp_out, exp_bit;
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_cell = (k % 4 == 0);
      exp_out  = ((k / 4) % 2 == 1);
      exp_bit  = (k % 8 == 0);
      checks++;
      if (cell_stb !== exp_cell) begin
        errors++;
        $display("FAIL default_cell k=%0d got %b exp %b", k, cell_stb, exp_cell);
      end
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL default_out k=%0d got %b exp %b", k, out, exp_out);
      end
      checks++;
      if (bit_stb !== exp_bit) begin
        errors++;
        $display("FAIL default_bit k=%0d got %b exp %b", k, bit_stb, exp_bit);
      end
    end
    checks++;
    if (bit_idx !== 5'd4) begin
      errors++;
      $display("FAIL default_bit_idx got %0d exp 4", bit_idx);
    end
  endtask

  task automatic test_ratio_change();
    logic prev_out, exp_cell, toggled;
    repeat (2) tick();
    div_i = 16'd6; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    checks++;
    if (div_busy !== 1'b1 || cell_stb !== 1'b0) begin
      errors++;
      $display("FAIL ratio_busy_set got busy=%b cell=%b exp busy=1 cell=0", div_busy, cell_stb);
    end
    prev_out = out;
    tick();
    checks++;
    if (div_busy !== 1'b0 || cell_stb !== 1'b1 || out === prev_out) begin
      errors++;
      $display("FAIL ratio_apply got busy=%b cell=%b out=%b exp busy=0 cell=1 out=%b",
               div_busy, cell_stb, out, ~prev_out);
    end
    prev_out = out;
    for (int j = 1; j <= 18; j++) begin
      tick();
      exp_cell = (j % 6 == 0);
      toggled  = (out !== prev_out);
      prev_out = out;
      checks++;
      if (cell_stb !== exp_cell) begin
        errors++;
        $display("FAIL ratio6_cell j=%0d got %b exp %b", j, cell_stb, exp_cell);
      end
      checks++;
      if (toggled !== exp_cell) begin
        errors++;
        $display("FAIL ratio6_out_toggle j=%0d got %b exp %b", j, toggled, exp_cell);
      end
    end
  endtask

  task automatic test_clamp();
    logic found;
    div_i = 16'd1; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    checks++;
    if (div_busy !== 1'b1) begin
      errors++;
      $display("FAIL clamp_busy got %b exp 1", div_busy);
    end
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      if (cell_stb) found = 1'b1;
    end
    checks++;
    if (!found || div_busy !== 1'b0) begin
      errors++;
      $display("FAIL clamp_boundary got found=%b busy=%b exp found=1 busy=0", found, div_busy);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++;
      if (cell_stb !== (j % 2 == 0)) begin
        errors++;
        $display("FAIL clamp_cell j=%0d got %b exp %b", j, cell_stb, (j % 2 == 0));
      end
    end
  endtask

  task automatic test_overwrite();
    en = 1'b0;
    div_i = 16'd9; div_load = 1'b1;
    tick();
    div_i = 16'd3;
    tick();
    div_load = 1'b0;
    checks++;
    if (div_busy !== 1'b1 || cell_stb !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_busy got busy=%b cell=%b exp busy=1 cell=0", div_busy, cell_stb);
    end
    en = 1'b1;
    tick();
    checks++;
    if (cell_stb !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_pre_cell got %b exp 0", cell_stb);
    end
    tick();
    checks++;
    if (cell_stb !== 1'b1 || div_busy !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_apply got cell=%b busy=%b exp cell=1 busy=0", cell_stb, div_busy);
    end
    for (int j = 1; j <= 6; j++) begin
      tick();
      checks++;
      if (cell_stb !== (j % 3 == 0)) begin
        errors++;
        $display("FAIL ratio3_cell j=%0d got %b exp %b", j, cell_stb, (j % 3 == 0));
      end
    end
  endtask

  task automatic test_enable();
    logic [14:0] saved;
    tick();
    saved = {out, bit_idx, sub_idx, frame_idx};
    en = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if ({cell_stb, bit_stb, block_stb} !== 3'b000) begin
        errors++;
        $display("FAIL en_low_strobes n=%0d got %b exp 000", n, {cell_stb, bit_stb, block_stb});
      end
      checks++;
      if ({out, bit_idx, sub_idx, frame_idx} !== saved) begin
        errors++;
        $display("FAIL en_low_frozen n=%0d got %h exp %h", n, {out, bit_idx, sub_idx, frame_idx}, saved);
      end
    end
    en = 1'b1;
    tick();
    checks++;
    if (cell_stb !== 1'b0) begin
      errors++;
      $display("FAIL en_resume_early got %b exp 0", cell_stb);
    end
    tick();
    checks++;
    if (cell_stb !== 1'b1) begin
      errors++;
      $display("FAIL en_resume_cell got %b exp 1", cell_stb);
    end
  endtask

  task automatic test_block();
    int nbits, nblk, blk_bit;
    sync_clr = 1'b1; div_i = 16'd2; div_load = 1'b1;
    tick();
    sync_clr = 1'b0; div_load = 1'b0;
    checks++;
    if ({out, cell_stb, bit_idx, sub_idx, frame_idx} !== 16'd0 || div_busy !== 1'b1) begin
      errors++;
      $display("FAIL sync_clr got out=%b cell=%b bit=%0d sub=%0d frame=%0d busy=%b exp zeros busy=1",
               out, cell_stb, bit_idx, sub_idx, frame_idx, div_busy);
    end
    repeat (2) tick();
    checks++;
    if (cell_stb !== 1'b0) begin
      errors++;
      $display("FAIL sync_clr_count got cell=%b exp 0", cell_stb);
    end
    tick();
    checks++;
    if (cell_stb !== 1'b1 || div_busy !== 1'b0) begin
      errors++;
      $display("FAIL sync_clr_apply got cell=%b busy=%b exp cell=1 busy=0", cell_stb, div_busy);
    end
    nbits = 0; nblk = 0; blk_bit = -1;
    for (int n = 0; n < 12288 * 4 + 16 && nbits < 12288; n++) begin
      tick();
      if (bit_stb) nbits++;
      if (block_stb) begin
        nblk++;
        blk_bit = nbits;
      end
      if (bit_stb && nbits == 32) begin
        checks++;
        if (bit_idx !== 5'd0 || sub_idx !== 1'b1) begin
          errors++;
          $display("FAIL sub_wrap got bit=%0d sub=%0d exp bit=0 sub=1", bit_idx, sub_idx);
        end
      end
      if (bit_stb && nbits == 64) begin
        checks++;
        if (sub_idx !== 1'b0 || frame_idx !== 8'd1) begin
          errors++;
          $display("FAIL frame_inc got sub=%0d frame=%0d exp sub=0 frame=1", sub_idx, frame_idx);
        end
      end
      if (bit_stb && nbits == 6400) begin
        checks++;
        if (frame_idx !== 8'd100) begin
          errors++;
          $display("FAIL frame_100 got %0d exp 100", frame_idx);
        end
      end
    end
    checks++;
    if (nbits != 12288) begin
      errors++;
      $display("FAIL block_bits got %0d exp 12288", nbits);
    end
    checks++;
    if ({bit_idx, sub_idx, frame_idx} !== 14'd0) begin
      errors++;
      $display("FAIL block_wrap_idx got bit=%0d sub=%0d frame=%0d exp 0", bit_idx, sub_idx, frame_idx);
    end
    checks++;
    if (nblk != 1 || blk_bit != 12288) begin
      errors++;
      $display("FAIL block_stb got count=%0d at_bit=%0d exp count=1 at_bit=12288", nblk, blk_bit);
    end
  endtask

  task automatic test_reset_midchange();
    logic found;
    found = 1'b0;
    for (int n = 0; n < 100 * 256 + 64 && !found; n++) begin
      tick();
      if (frame_idx == 8'd100) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reach_frame_100 got frame=%0d exp 100", frame_idx);
    end
    div_i = 16'd7; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    checks++;
    if (div_busy !== 1'b1 || frame_idx !== 8'd100) begin
      errors++;
      $display("FAIL pre_reset got busy=%b frame=%0d exp busy=1 frame=100", div_busy, frame_idx);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({div_busy, out, cell_stb, bit_stb, block_stb} !== 5'b0 ||
        {bit_idx, sub_idx, frame_idx} !== 14'd0) begin
      errors++;
      $display("FAIL async_reset got busy=%b out=%b cell=%b bit_stb=%b blk=%b bit=%0d sub=%0d frame=%0d exp zeros",
               div_busy, out, cell_stb, bit_stb, block_stb, bit_idx, sub_idx, frame_idx);
    end
    tick();
    nrst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (cell_stb !== (k % 4 == 0) || div_busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_ratio k=%0d got cell=%b busy=%b exp cell=%b busy=0",
                 k, cell_stb, div_busy, (k % 4 == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_ratio();
    test_ratio_change();
    test_clamp();
    test_overwrite();
    test_enable();
    test_block();
    test_reset_midchange();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
